// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: shared defaults and window-decode helper for the data_sram responder
package data_sram_responder_pkg;
  localparam int DSRAM_ADDR_W = 10;
  localparam logic [31:0] DSRAM_BASE = 32'h1c08_0000;
  localparam int DSRAM_LATENCY = 1;
  localparam int MAX_LATENCY = 3;
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base, input int aw);
    return (addr >> (aw + 2)) == (base >> (aw + 2));
  endfunction
endpackage

// File: rtl/data_sram_responder_byte_we_ram.sv
// byte_we_ram: 2**ADDR_W x 32 single-port RAM, sync read, per-byte write enables, no reset
//   clk   in  clock
//   en    in  access enable; we==0 reads into rdata, otherwise writes enabled bytes
//   we    in  byte write enables
//   addr  in  word address
//   wdata in  write data
//   rdata out read data, updated only by reads
module byte_we_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      if (we == 4'b0) rdata <= mem[addr];
    end
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: data_sram responder with window check, LATENCY-cycle load pipe and ld/st counters
//   clk, reset        clock, async active-high reset
//   data_sram_en/we/addr/wdata   request (we==0 is a load), one per cycle, no backpressure
//   data_sram_rdata/rvalid       load response LATENCY cycles after the request, rdata held otherwise
//   data_sram_aerr               out-of-window flag: with rvalid for loads, next cycle for stores
//   ld_cnt, st_cnt               accepted loads / stores since reset, wrapping
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          ADDR_W  = DSRAM_ADDR_W,
  parameter logic [31:0] BASE    = DSRAM_BASE,
  parameter int          LATENCY = DSRAM_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        data_sram_aerr,
  output logic [31:0] ld_cnt,
  output logic [31:0] st_cnt
);
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("data_sram_responder: LATENCY must be 1..3");
  end
  logic               hit, ld, st, h, st_miss;
  logic [31:0]        ram_q, d0;
  logic [LATENCY-1:0] v, m;
  assign hit = in_window(data_sram_addr, BASE, ADDR_W);
  assign ld = data_sram_en && data_sram_we == 4'b0;
  assign st = data_sram_en && data_sram_we != 4'b0;
  byte_we_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .en(data_sram_en && hit),
    .we(data_sram_we),
    .addr(data_sram_addr[ADDR_W+1:2]),
    .wdata(data_sram_wdata),
    .rdata(ram_q)
  );
  // The RAM output register is pipe stage 0; h masks it to zero after reset or a missed load.
  assign d0 = h ? ram_q : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v <= '0;
      m <= '0;
      h <= 1'b0;
      st_miss <= 1'b0;
      ld_cnt <= '0;
      st_cnt <= '0;
    end else begin
      v <= LATENCY'({v, ld});
      m <= LATENCY'({m, ld && !hit});
      if (ld) h <= hit;
      st_miss <= st && !hit;
      if (ld) ld_cnt <= ld_cnt + 32'd1;
      if (st) st_cnt <= st_cnt + 32'd1;
    end
  if (LATENCY == 1) begin : g_l1
    assign data_sram_rdata = d0;
  end else begin : g_ln
    logic [31:0] d [LATENCY-1];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        for (int i = 0; i < LATENCY - 1; i++) d[i] <= '0;
      end else begin
        if (v[0]) d[0] <= d0;
        for (int i = 1; i < LATENCY - 1; i++)
          if (v[i]) d[i] <= d[i-1];
      end
    assign data_sram_rdata = d[LATENCY-2];
  end
  assign data_sram_rvalid = v[LATENCY-1];
  assign data_sram_aerr = (v[LATENCY-1] && m[LATENCY-1]) || st_miss;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: randomized + directed bench for LATENCY 1..3 against a queue-based model
module tb_data_sram_responder;
  localparam logic [31:0] BASE = 32'h1c08_0000;
  logic        clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic [3:0]  we = 4'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata [3], ld_cnt [3], st_cnt [3];
  logic        rvalid [3], aerr [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_sram_responder #(.ADDR_W(10), .BASE(BASE), .LATENCY(g + 1)) u (
      .clk(clk), .reset(reset),
      .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(rdata[g]), .data_sram_rvalid(rvalid[g]), .data_sram_aerr(aerr[g]),
      .ld_cnt(ld_cnt[g]), .st_cnt(st_cnt[g])
    );
  end
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat=%0d: got %h want %h at %0t", name, i + 1, act, exp, $time);
    end
  endtask
  typedef struct {int cyc; logic [31:0] d; bit e;} ld_t;
  ld_t         lq [$];
  int          hd [3] = '{0, 0, 0};
  int          rv_seen [3] = '{0, 0, 0};
  int          cyc = 0;
  logic [31:0] mem [1024];
  logic [31:0] m_ld = '0, m_st = '0;
  logic [31:0] m_rd [3] = '{32'h0, 32'h0, 32'h0};
  bit          erv [3], eae [3];
  bit          pre = 1'b0;
  always @(posedge clk) begin
    bit stm, hit;
    int idx;
    cyc++;
    stm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      erv[i] = 1'b0;
      eae[i] = 1'b0;
    end
    if (reset) begin
      lq.delete();
      m_ld = '0;
      m_st = '0;
      for (int i = 0; i < 3; i++) begin
        hd[i] = 0;
        rv_seen[i] = 0;
        m_rd[i] = '0;
      end
    end else begin
      hit = addr[31:12] == BASE[31:12];
      idx = int'(addr[11:2]);
      if (en && we != 4'b0) begin
        m_st++;
        if (hit) begin
          for (int b = 0; b < 4; b++)
            if (we[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end else stm = 1'b1;
      end else if (en) begin
        m_ld++;
        lq.push_back('{cyc, hit ? mem[idx] : 32'h0, !hit});
      end
      if (pre) m_st = 32'hffff_ffff;
      for (int i = 0; i < 3; i++) begin
        eae[i] = stm;
        if (hd[i] < lq.size() && lq[hd[i]].cyc + i == cyc) begin
          erv[i] = 1'b1;
          m_rd[i] = lq[hd[i]].d;
          eae[i] = eae[i] | lq[hd[i]].e;
          hd[i]++;
        end
      end
    end
    #2;
    for (int i = 0; i < 3; i++) begin
      if (rvalid[i] === 1'b1) rv_seen[i]++;
      chk("model_rvalid", i, 32'(rvalid[i]), 32'(erv[i]));
      chk("model_rdata", i, rdata[i], m_rd[i]);
      chk("model_aerr", i, 32'(aerr[i]), 32'(eae[i]));
      chk("model_ld_cnt", i, ld_cnt[i], m_ld);
      chk("model_st_cnt", i, st_cnt[i], m_st);
    end
  end
  task automatic req(bit e, logic [3:0] w, logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    en = e;
    we = w;
    addr = a;
    wdata = d;
  endtask
  task automatic check_load(logic [31:0] a, logic [31:0] exp, bit ee, string name);
    req(1'b1, 4'b0, a, $urandom);
    for (int s = 1; s <= 3; s++) begin
      @(posedge clk);
      #2;
      if (s == 1) en = 1'b0;
      for (int i = 0; i < 3; i++)
        if (i + 1 == s) begin
          chk({name, "_rvalid"}, i, 32'(rvalid[i]), 32'd1);
          chk({name, "_rdata"}, i, rdata[i], exp);
          chk({name, "_aerr"}, i, 32'(aerr[i]), 32'(ee));
        end
    end
  endtask
  function automatic logic [31:0] rnd_addr(bit allow_miss);
    if (allow_miss && $urandom_range(0, 4) == 0)
      return $urandom_range(0, 1) != 0 ? BASE - 4 * $urandom_range(1, 64) : BASE + 4096 + $urandom_range(0, 4095);
    return BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
  endfunction
  initial begin
    logic [31:0] init [16];
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int w = 0; w < 16; w++) begin
      init[w] = $urandom;
      req(1'b1, 4'hf, BASE + 4 * w, init[w]);
    end
    req(1'b1, 4'hf, BASE + 8, 32'hdead_beef);
    check_load(BASE + 8, 32'hdead_beef, 1'b0, "st_ld");
    req(1'b1, 4'hf, BASE + 12, 32'h1122_3344);
    req(1'b1, 4'b0101, BASE + 12, 32'haabb_ccdd);
    check_load(BASE + 12, 32'h11bb_33dd, 1'b0, "mask");
    check_load(BASE - 4, 32'h0, 1'b1, "miss_ld");
    req(1'b1, 4'hf, BASE + 4096, 32'h5a5a_5a5a);
    @(posedge clk);
    #2;
    en = 1'b0;
    for (int i = 0; i < 3; i++) chk("st_miss_aerr", i, 32'(aerr[i]), 32'd1);
    check_load(BASE, init[0], 1'b0, "miss_noalias");
    req(1'b1, 4'b0, BASE + 4, 32'h0);
    req(1'b1, 4'b0, BASE + 16, 32'h0);
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ld_cnt", i, ld_cnt[i], 32'h0);
      chk("rst_st_cnt", i, st_cnt[i], 32'h0);
      chk("rst_rvalid", i, 32'(rvalid[i]), 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 64; k++) req(1'b1, 4'b0, rnd_addr(1'b0), $urandom);
    req(1'b0, 4'b0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("stream_ld_cnt", i, ld_cnt[i], 32'd64);
      chk("stream_pulses", i, 32'(rv_seen[i]), 32'd64);
    end
    for (int k = 0; k < 400; k++)
      req($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0 ? 4'b0 : 4'($urandom), rnd_addr(1'b1), $urandom);
    for (int k = 0; k < 30; k++) req(1'b0, 4'($urandom), $urandom, $urandom);
    @(negedge clk);
    force g_dut[0].u.st_cnt = 32'hffff_ffff;
    force g_dut[1].u.st_cnt = 32'hffff_ffff;
    force g_dut[2].u.st_cnt = 32'hffff_ffff;
    pre = 1'b1;
    @(negedge clk);
    release g_dut[0].u.st_cnt;
    release g_dut[1].u.st_cnt;
    release g_dut[2].u.st_cnt;
    pre = 1'b0;
    en = 1'b1;
    we = 4'hf;
    addr = BASE + 20;
    wdata = 32'h0bad_f00d;
    req(1'b1, 4'hf, BASE + 24, 32'h600d_cafe);
    req(1'b0, 4'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) chk("wrap_st_cnt", i, st_cnt[i], 32'd1);
    check_load(BASE + 24, 32'h600d_cafe, 1'b0, "wrap_ld");
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
